// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and constants for the UART frame transmitter
package uart_tx_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Bit counter width, kept at least one bit so a 1-bit frame still synthesises.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - data shift register and bit counter for one frame
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_bit,
  output logic                  o_last
);

  localparam int CW = cnt_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic                  r_primed;

  assign o_bit  = r_shift[0];
  assign o_last = (r_cnt == CW'(DATA_WIDTH - 1));

  // The first shift (leaving START) places bit 0 on the line without advancing
  // the counter, so r_cnt indexes the data bit currently being transmitted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_primed <= 1'b0;
    end else if (i_load) begin
      r_shift  <= i_data;
      r_cnt    <= '0;
      r_primed <= 1'b0;
    end else if (i_shift) begin
      r_shift  <= r_shift >> 1;
      r_primed <= 1'b1;
      if (r_primed && !o_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// rtl/uart_tx_frame_serializer.sv - UART transmit framer: start, data LSB first, optional parity, stop
// Define UART_TX_TWO_STOP_EN for a two-cycle stop bit.
module uart_tx_frame_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  tx_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic                  tx_out,
  output logic                  busy
);

  tx_state_e r_state;
  logic      r_tx;
  logic      r_busy;
  logic      r_par_en;
  logic      r_par_bit;
`ifdef UART_TX_TWO_STOP_EN
  logic      r_stop2;
`endif

  logic w_load;
  logic w_shift;
  logic w_bit;
  logic w_last;

  assign w_load  = (r_state == IDLE) && data_valid;
  assign w_shift = (r_state == START) || ((r_state == DATA) && !w_last);

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .i_clk   (tx_clk),
    .i_rst   (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (p_data),
    .o_bit   (w_bit),
    .o_last  (w_last)
  );

  assign tx_out = r_tx;
  assign busy   = r_busy;

  // r_tx is loaded with the level for the state being entered, so it is a
  // clean flop output on the line.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      r_stop2   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (data_valid) begin
            r_par_en  <= parity_enable;
            r_par_bit <= (parity_type == PARITY_ODD) ? ~^p_data : ^p_data;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= START;
          end
        end
        START: begin
          r_tx    <= w_bit;
          r_state <= DATA;
        end
        DATA: begin
          if (w_last) begin
            if (r_par_en) begin
              r_tx    <= r_par_bit;
              r_state <= PARITY;
            end else begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end
          end else begin
            r_tx <= w_bit;
          end
        end
        PARITY: begin
          r_tx    <= 1'b1;
          r_state <= STOP;
        end
        STOP: begin
          r_tx <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
          if (!r_stop2) begin
            r_stop2 <= 1'b1;
          end else begin
            r_stop2 <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
`else
          r_busy  <= 1'b0;
          r_state <= IDLE;
`endif
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// tb/tb_uart_tx_frame_serializer.sv - scoreboard bench for uart_tx_frame_serializer
module tb_uart_tx_frame_serializer;

  logic       tx_clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       parity_enable = 1'b0;
  logic       parity_type = 1'b0;
  logic       tx_out;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic tx;
    logic bsy;
  } exp_t;

  exp_t exp_q[$];

  uart_tx_frame_serializer #(.DATA_WIDTH(8)) dut (
    .tx_clk        (tx_clk),
    .rst           (rst),
    .p_data        (p_data),
    .data_valid    (data_valid),
    .parity_enable (parity_enable),
    .parity_type   (parity_type),
    .tx_out        (tx_out),
    .busy          (busy)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic push_frame(input logic [7:0] d, input logic pen, input logic pt);
    exp_q.push_back({1'b0, 1'b1});
    for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b1});
    if (pen) exp_q.push_back({(pt ? ~^d : ^d), 1'b1});
    exp_q.push_back({1'b1, 1'b1});
`ifdef UART_TX_TWO_STOP_EN
    exp_q.push_back({1'b1, 1'b1});
`endif
  endtask

  task automatic start_frame(input logic [7:0] d, input logic pen, input logic pt, input logic hold);
    @(posedge tx_clk);
    #1;
    p_data        = d;
    parity_enable = pen;
    parity_type   = pt;
    data_valid    = 1'b1;
    push_frame(d, pen, pt);
    @(posedge tx_clk);
    #1;
    if (!hold) data_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int chg_at, input logic [7:0] chg_d,
                       input int drop_at, input int abort_at);
    int   idx = 0;
    exp_t e;
    while (exp_q.size() > 0) begin
      @(negedge tx_clk);
      e = exp_q.pop_front();
      vectors++;
      if (tx_out !== e.tx) begin
        miscompares++;
        $display("FAIL %s cycle%0d tx_out: got %b want %b", name, idx, tx_out, e.tx);
      end
      vectors++;
      if (busy !== e.bsy) begin
        miscompares++;
        $display("FAIL %s cycle%0d busy: got %b want %b", name, idx, busy, e.bsy);
      end
      if (idx == chg_at) begin
        p_data        = chg_d;
        parity_enable = 1'b0;
        parity_type   = ~parity_type;
      end
      if (idx == drop_at) data_valid = 1'b0;
      if (idx == abort_at) begin
        rst = 1'b1;
        #1;
        vectors++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL %s async_abort: got tx_out=%b busy=%b want 1 0", name, tx_out, busy);
        end
        exp_q.delete();
      end
      idx++;
    end
    @(negedge tx_clk);
    vectors++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_after: got tx_out=%b busy=%b want 1 0", name, tx_out, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: got tx_out=%b busy=%b want 1 0", tx_out, busy);
    end
    repeat (2) @(negedge tx_clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge tx_clk);
      vectors++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle cycle%0d: got tx_out=%b busy=%b want 1 0", i, tx_out, busy);
      end
    end
  endtask

  task automatic test_no_parity();
    start_frame(8'h2B, 1'b0, 1'b0, 1'b0);
    drain("no_parity", -1, 8'h00, -1, -1);
  endtask

  task automatic test_odd_parity();
    start_frame(8'hA9, 1'b1, 1'b1, 1'b0);
    drain("odd_parity", 3, 8'h00, -1, -1);
  endtask

  task automatic test_even_parity();
    start_frame(8'h2A, 1'b1, 1'b0, 1'b0);
    drain("even_parity", -1, 8'h00, -1, -1);
  endtask

  task automatic test_back_to_back();
    start_frame(8'h2B, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({1'b1, 1'b0});
    push_frame(8'hFF, 1'b0, 1'b0);
    drain("back_to_back", 3, 8'hFF, 15, -1);
  endtask

  task automatic test_abort();
    start_frame(8'h2B, 1'b0, 1'b0, 1'b0);
    drain("abort", -1, 8'h00, -1, 5);
    repeat (3) @(negedge tx_clk);
    rst = 1'b0;
    start_frame(8'h2A, 1'b1, 1'b0, 1'b0);
    drain("after_abort", -1, 8'h00, -1, -1);
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_odd_parity();
    test_even_parity();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
